vg_wrpc: RTL and testbench



---
 rtl/vg_wrpc.sv | 213 +++++++++++++++++++++
 tb/tb_vg_wrpc.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vg_wrpc.sv
// ============================================================================
// Module   : vg_wrpc
// Purpose  : VG93 companion logic. Generates the VG93 clock with normal /
//            turbo / stopped modes and produces a precompensated write pulse
//            whose delay is taken from a small programmable table selected by
//            the VG93 precompensation hints.
// Ports    : fclk            - sole clock, all state on posedge
//            rst_n           - asynchronous active-low reset
//            step, vg_drq    - VG93 step / DRQ (async, turbo control)
//            vg_wd           - VG93 write-data pulse (async)
//            vg_sl, vg_sr,
//            vg_tr43         - VG93 precompensation hints (async)
//            clk_mode        - 00 normal, 01 turbo, 10 auto turbo, 11 stopped
//            cfg_we/addr/data- delay table write port, addr 7 clears ovl
//            vg_clk          - VG93 clock
//            turbo           - current turbo state
//            vg_wrd          - precompensated write pulse
//            ovl             - sticky overlap flag
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vg_wrpc #(
  parameter int CNT_W     = 4,
  parameter int PULSE_LEN = 7,
  parameter int CLK_DIV   = 7
) (
  input  logic             fclk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             vg_drq,
  input  logic             vg_wd,
  input  logic             vg_sl,
  input  logic             vg_sr,
  input  logic             vg_tr43,
  input  logic [1:0]       clk_mode,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_data,
  output logic             vg_clk,
  output logic             turbo,
  output logic             vg_wrd,
  output logic             ovl
);

  localparam logic [3:0]       c_div_m1  = 4'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] c_plen_m1 = CNT_W'(PULSE_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_PULSE = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] tbl_rst(input int idx);
    case (idx)
      0:       tbl_rst = CNT_W'(4);
      1:       tbl_rst = CNT_W'(11);
      2:       tbl_rst = CNT_W'(0);
      3:       tbl_rst = CNT_W'(14);
      default: tbl_rst = CNT_W'(7);
    endcase
  endfunction

  // ---------------------------------------------------------------- sync ----
  logic [2:0] r_step_s, r_drq_s, r_wd_s;
  logic [1:0] r_sl_s, r_sr_s, r_tr_s;

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_s <= '0;
      r_drq_s  <= '0;
      r_wd_s   <= '0;
      r_sl_s   <= '0;
      r_sr_s   <= '0;
      r_tr_s   <= '0;
    end else begin
      r_step_s <= {r_step_s[1:0], step};
      r_drq_s  <= {r_drq_s[1:0], vg_drq};
      r_wd_s   <= {r_wd_s[1:0], vg_wd};
      r_sl_s   <= {r_sl_s[0], vg_sl};
      r_sr_s   <= {r_sr_s[0], vg_sr};
      r_tr_s   <= {r_tr_s[0], vg_tr43};
    end
  end

  logic w_step_stb, w_drq_stb, w_wd_stb;
  assign w_step_stb = r_step_s[1] & ~r_step_s[2];
  assign w_drq_stb  = r_drq_s[1]  & ~r_drq_s[2];
  assign w_wd_stb   = r_wd_s[1]   & ~r_wd_s[2];

  // ------------------------------------------------------- clock section ----
  logic [3:0] r_presc;
  logic       r_half;  // normal mode: first of the two strobes already seen
  logic       w_stb;

  assign w_stb = (r_presc == c_div_m1);

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_half  <= 1'b0;
      vg_clk  <= 1'b0;
      turbo   <= 1'b0;
    end else begin
      r_presc <= w_stb ? 4'd0 : r_presc + 4'd1;

      case (clk_mode)
        2'b01:   turbo <= 1'b1;
        2'b10: begin
          // DRQ has priority over a coincident step edge.
          if (w_drq_stb)       turbo <= 1'b0;
          else if (w_step_stb) turbo <= 1'b1;
        end
        default: turbo <= 1'b0;
      endcase

      // vg_clk only ever changes on a strobe, so every phase lasts at least
      // CLK_DIV cycles no matter when the mode changes.
      if (w_stb) begin
        if (clk_mode == 2'b11) begin
          vg_clk <= 1'b0;
          r_half <= 1'b0;
        end else if (turbo || r_half) begin
          vg_clk <= ~vg_clk;
          r_half <= 1'b0;
        end else begin
          r_half <= 1'b1;
        end
      end
    end
  end

  // ------------------------------------------------------- delay table ------
  logic [CNT_W-1:0] r_tbl [0:4];

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) r_tbl[i] <= tbl_rst(i);
    end else begin
      for (int i = 0; i < 5; i++)
        if (cfg_we && (cfg_addr == 3'(i))) r_tbl[i] <= cfg_data;
    end
  end

  // Zone lookup; hint order is {sl, tr43, sr}.
  logic [CNT_W-1:0] w_dly;
  always_comb begin
    w_dly = r_tbl[4];
    case ({r_sl_s[1], r_tr_s[1], r_sr_s[1]})
      3'b100:  w_dly = r_tbl[0];
      3'b001:  w_dly = r_tbl[1];
      3'b110:  w_dly = r_tbl[2];
      3'b011:  w_dly = r_tbl[3];
      default: w_dly = r_tbl[4];
    endcase
  end

  // ------------------------------------------------------- write pulse ------
  state_t           r_state;
  logic [CNT_W-1:0] r_dcnt, r_pcnt;

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_dcnt  <= '0;
      r_pcnt  <= '0;
      vg_wrd  <= 1'b0;
    end else if (w_wd_stb) begin
      // A new write strobe always restarts, aborting any pulse in progress.
      r_state <= ST_DELAY;
      r_dcnt  <= w_dly;
      vg_wrd  <= 1'b0;
    end else begin
      case (r_state)
        ST_DELAY: begin
          if (r_dcnt != '0) begin
            r_dcnt <= r_dcnt - 1'b1;
          end else begin
            r_state <= ST_PULSE;
            r_pcnt  <= c_plen_m1;
            vg_wrd  <= 1'b1;
          end
        end
        ST_PULSE: begin
          if (r_pcnt != '0) begin
            r_pcnt <= r_pcnt - 1'b1;
          end else begin
            r_state <= ST_IDLE;
            vg_wrd  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          vg_wrd  <= 1'b0;
        end
      endcase
    end
  end

  // Overlap flag: setting wins over a same-cycle clear.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n)
      ovl <= 1'b0;
    else if (w_wd_stb && (r_state != ST_IDLE))
      ovl <= 1'b1;
    else if (cfg_we && (cfg_addr == 3'd7))
      ovl <= 1'b0;
  end

endmodule

`default_nettype wire

// File: tb/tb_vg_wrpc.sv
// ============================================================================
// Module   : tb_vg_wrpc
// Purpose  : Directed self-checking bench for vg_wrpc (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vg_wrpc;

  localparam int CNT_W = 4;

  logic             fclk = 1'b0;
  logic             rst_n = 1'b0;
  logic             step = 1'b0, vg_drq = 1'b0, vg_wd = 1'b0;
  logic             vg_sl = 1'b0, vg_sr = 1'b0, vg_tr43 = 1'b0;
  logic [1:0]       clk_mode = 2'b00;
  logic             cfg_we = 1'b0;
  logic [2:0]       cfg_addr = 3'd0;
  logic [CNT_W-1:0] cfg_data = '0;
  logic             vg_clk, turbo, vg_wrd, ovl;

  int checks = 0;
  int failures = 0;

  vg_wrpc #(.CNT_W(4), .PULSE_LEN(7), .CLK_DIV(7)) dut (
    .fclk(fclk), .rst_n(rst_n), .step(step), .vg_drq(vg_drq), .vg_wd(vg_wd),
    .vg_sl(vg_sl), .vg_sr(vg_sr), .vg_tr43(vg_tr43), .clk_mode(clk_mode),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .vg_clk(vg_clk), .turbo(turbo), .vg_wrd(vg_wrd), .ovl(ovl)
  );

  always #5 fclk = ~fclk;

  // Shortest completed vg_clk phase seen outside reset.
  int   min_phase = 1000;
  int   run_len = 0;
  logic prev_clk = 1'b0;
  bit   started = 1'b0;
  always @(negedge fclk) begin
    if (!rst_n) begin
      run_len = 0; started = 1'b0; prev_clk = 1'b0;
    end else if (vg_clk === prev_clk) begin
      run_len++;
    end else begin
      if (started && run_len < min_phase) min_phase = run_len;
      started = 1'b1; run_len = 1; prev_clk = vg_clk;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge fclk); #1; end
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [CNT_W-1:0] d);
    tick(1); cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick(1); cfg_we = 1'b0;
  endtask

  // Raises vg_wd at k=0 (just after an edge); rise/fall are the sample
  // indices at which vg_wrd is first seen high / low again. Optional cfg
  // write driven after sample cfg_at (captured at edge cfg_at+1).
  task automatic pulse_wd(input logic sl, input logic tr, input logic sr,
                          input int cfg_at, input logic [2:0] ca,
                          input logic [CNT_W-1:0] cd,
                          output int rise, output int fall);
    rise = -1; fall = -1;
    tick(1); vg_sl = sl; vg_tr43 = tr; vg_sr = sr;
    tick(3); vg_wd = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      tick(1);
      if (vg_wrd === 1'b1 && rise < 0) rise = k;
      else if (rise >= 0 && fall < 0 && vg_wrd === 1'b0) fall = k;
      if (k == 3) vg_wd = 1'b0;
      if (k == cfg_at) begin cfg_we = 1'b1; cfg_addr = ca; cfg_data = cd; end
      if (k == cfg_at + 1) cfg_we = 1'b0;
    end
  endtask

  task automatic measure_clk(output int hi, output int lo);
    logic p;
    bit   found;
    int   h, l;
    hi = -1; lo = -1; found = 1'b0;
    p = vg_clk;
    for (int n = 0; n < 200 && !found; n++) begin
      tick(1);
      if (p === 1'b0 && vg_clk === 1'b1) found = 1'b1;
      p = vg_clk;
    end
    if (found) begin
      h = 1;
      while (h < 200) begin tick(1); if (vg_clk !== 1'b1) break; h++; end
      l = 1;
      while (l < 200) begin tick(1); if (vg_clk !== 1'b0) break; l++; end
      hi = h; lo = l;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (vg_clk !== 1'b0) begin failures++; $display("FAIL reset_vg_clk got=%b want=0", vg_clk); end
    checks++; if (turbo !== 1'b0) begin failures++; $display("FAIL reset_turbo got=%b want=0", turbo); end
    checks++; if (vg_wrd !== 1'b0) begin failures++; $display("FAIL reset_vg_wrd got=%b want=0", vg_wrd); end
    checks++; if (ovl !== 1'b0) begin failures++; $display("FAIL reset_ovl got=%b want=0", ovl); end
    #20 rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_clock_normal();
    int hi, lo;
    measure_clk(hi, lo);
    checks++; if (hi !== 14) begin failures++; $display("FAIL normal_clk_high got=%0d want=14", hi); end
    checks++; if (lo !== 14) begin failures++; $display("FAIL normal_clk_low got=%0d want=14", lo); end
  endtask

  task automatic test_default_pulse();
    int r, f;
    pulse_wd(1'b0, 1'b0, 1'b0, -1, 3'd0, '0, r, f);
    checks++; if (r !== 11) begin failures++; $display("FAIL default_rise got=%0d want=11", r); end
    checks++; if (f - r !== 7) begin failures++; $display("FAIL default_width got=%0d want=7", f - r); end
  endtask

  task automatic test_table_write();
    int r, f;
    cfg_write(3'd2, 4'd3);
    pulse_wd(1'b1, 1'b1, 1'b0, -1, 3'd0, '0, r, f);
    checks++; if (r !== 7) begin failures++; $display("FAIL inner_left_rise got=%0d want=7", r); end
    checks++; if (f - r !== 7) begin failures++; $display("FAIL inner_left_width got=%0d want=7", f - r); end
    checks++; if (ovl !== 1'b0) begin failures++; $display("FAIL inner_left_ovl got=%b want=0", ovl); end
  endtask

  task automatic test_turbo();
    int hi, lo, highs;
    clk_mode = 2'b10; tick(5);
    checks++; if (turbo !== 1'b0) begin failures++; $display("FAIL auto_idle_turbo got=%b want=0", turbo); end
    step = 1'b1; tick(4); step = 1'b0; tick(2);
    checks++; if (turbo !== 1'b1) begin failures++; $display("FAIL auto_step_turbo got=%b want=1", turbo); end
    tick(20); measure_clk(hi, lo);
    checks++; if (hi !== 7 || lo !== 7) begin failures++; $display("FAIL auto_turbo_period got=%0d/%0d want=7/7", hi, lo); end
    vg_drq = 1'b1; tick(4); vg_drq = 1'b0; tick(2);
    checks++; if (turbo !== 1'b0) begin failures++; $display("FAIL auto_drq_turbo got=%b want=0", turbo); end
    tick(30); measure_clk(hi, lo);
    checks++; if (hi !== 14 || lo !== 14) begin failures++; $display("FAIL auto_normal_period got=%0d/%0d want=14/14", hi, lo); end
    step = 1'b1; tick(4); step = 1'b0; tick(3);
    checks++; if (turbo !== 1'b1) begin failures++; $display("FAIL auto_step2_turbo got=%b want=1", turbo); end
    step = 1'b1; vg_drq = 1'b1; tick(4);
    checks++; if (turbo !== 1'b0) begin failures++; $display("FAIL auto_both_turbo got=%b want=0", turbo); end
    step = 1'b0; vg_drq = 1'b0;
    clk_mode = 2'b01; tick(2);
    checks++; if (turbo !== 1'b1) begin failures++; $display("FAIL forced_turbo got=%b want=1", turbo); end
    tick(20); measure_clk(hi, lo);
    checks++; if (hi !== 7 || lo !== 7) begin failures++; $display("FAIL forced_period got=%0d/%0d want=7/7", hi, lo); end
    // Mode changes at awkward moments; phase lengths are checked at the end.
    clk_mode = 2'b00; tick(3); clk_mode = 2'b01; tick(9);
    clk_mode = 2'b10; tick(4); clk_mode = 2'b00; tick(11);
    clk_mode = 2'b01; tick(16); clk_mode = 2'b00; tick(5);
    clk_mode = 2'b11; tick(2);
    checks++; if (turbo !== 1'b0) begin failures++; $display("FAIL stopped_turbo got=%b want=0", turbo); end
    tick(20);
    highs = 0;
    for (int i = 0; i < 40; i++) begin tick(1); if (vg_clk !== 1'b0) highs++; end
    checks++; if (highs !== 0) begin failures++; $display("FAIL stopped_clk_high_samples got=%0d want=0", highs); end
    clk_mode = 2'b00; tick(40);
    measure_clk(hi, lo);
    checks++; if (hi !== 14 || lo !== 14) begin failures++; $display("FAIL restart_period got=%0d/%0d want=14/14", hi, lo); end
  endtask

  task automatic test_overlap();
    int r, r2, f2;
    logic w2, w3, o3;
    cfg_write(3'd7, '0);
    tick(1); vg_sl = 1'b0; vg_tr43 = 1'b0; vg_sr = 1'b0;
    tick(3); vg_wd = 1'b1;
    r = -1;
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      if (k == 3) vg_wd = 1'b0;
      if (vg_wrd === 1'b1) begin r = k; break; end
    end
    checks++; if (r !== 11) begin failures++; $display("FAIL overlap_first_rise got=%0d want=11", r); end
    tick(1); vg_wd = 1'b1;
    w2 = 1'bx; w3 = 1'bx; o3 = 1'bx; r2 = -1; f2 = -1;
    for (int j = 1; j <= 40; j++) begin
      tick(1);
      if (j == 2) w2 = vg_wrd;
      if (j == 3) begin w3 = vg_wrd; o3 = ovl; vg_wd = 1'b0; end
      if (j > 3 && vg_wrd === 1'b1 && r2 < 0) r2 = j;
      else if (r2 >= 0 && f2 < 0 && vg_wrd === 1'b0) f2 = j;
    end
    checks++; if (w2 !== 1'b1) begin failures++; $display("FAIL overlap_hold got=%b want=1", w2); end
    checks++; if (w3 !== 1'b0) begin failures++; $display("FAIL overlap_drop got=%b want=0", w3); end
    checks++; if (o3 !== 1'b1) begin failures++; $display("FAIL overlap_ovl got=%b want=1", o3); end
    checks++; if (r2 !== 11 || f2 !== 18) begin failures++; $display("FAIL overlap_rerise got=%0d..%0d want=11..18", r2, f2); end
    cfg_write(3'd5, 4'd1); cfg_write(3'd6, 4'd1);
    checks++; if (ovl !== 1'b1) begin failures++; $display("FAIL ovl_ignored_addr got=%b want=1", ovl); end
    cfg_write(3'd7, '0);
    checks++; if (ovl !== 1'b0) begin failures++; $display("FAIL ovl_clear got=%b want=0", ovl); end
    // Second strobe while busy coinciding with a clear: set must win.
    vg_wd = 1'b1; tick(2); vg_wd = 1'b0;
    pulse_wd(1'b0, 1'b0, 1'b0, 2, 3'd7, '0, r, f2);
    checks++; if (ovl !== 1'b1) begin failures++; $display("FAIL ovl_set_vs_clear got=%b want=1", ovl); end
    checks++; if (r !== 11) begin failures++; $display("FAIL restart_rise got=%0d want=11", r); end
    cfg_write(3'd7, '0);
  endtask

  task automatic test_table_timing();
    int r, f;
    pulse_wd(1'b0, 1'b0, 1'b0, 5, 3'd4, 4'd2, r, f);
    checks++; if (r !== 11) begin failures++; $display("FAIL write_in_flight_rise got=%0d want=11", r); end
    pulse_wd(1'b0, 1'b0, 1'b0, -1, 3'd0, '0, r, f);
    checks++; if (r !== 6) begin failures++; $display("FAIL new_value_rise got=%0d want=6", r); end
    pulse_wd(1'b0, 1'b0, 1'b0, 2, 3'd4, 4'd9, r, f);
    checks++; if (r !== 6) begin failures++; $display("FAIL same_cycle_old_rise got=%0d want=6", r); end
    pulse_wd(1'b0, 1'b0, 1'b0, -1, 3'd0, '0, r, f);
    checks++; if (r !== 13 || f - r !== 7) begin failures++; $display("FAIL same_cycle_next got=%0d/%0d want=13/7", r, f - r); end
    cfg_write(3'd4, 4'd7);
  endtask

  task automatic test_reset_mid_pulse();
    int r, f, k;
    logic [2:0] hints [5];
    int         want  [5];
    hints[0] = 3'b100; want[0] = 8;
    hints[1] = 3'b001; want[1] = 15;
    hints[2] = 3'b110; want[2] = 4;
    hints[3] = 3'b011; want[3] = 18;
    hints[4] = 3'b111; want[4] = 11;
    cfg_write(3'd0, 4'd1);
    tick(1); vg_sl = 1'b0; vg_tr43 = 1'b0; vg_sr = 1'b0; tick(3);
    vg_wd = 1'b1; tick(2); vg_wd = 1'b0; tick(2); vg_wd = 1'b1; tick(2); vg_wd = 1'b0;
    k = 0;
    while (vg_wrd !== 1'b1 && k < 40) begin tick(1); k++; end
    checks++; if (vg_wrd !== 1'b1) begin failures++; $display("FAIL pre_reset_pulse got=%b want=1", vg_wrd); end
    checks++; if (ovl !== 1'b1) begin failures++; $display("FAIL pre_reset_ovl got=%b want=1", ovl); end
    tick(2); #2;
    rst_n = 1'b0; #1;
    checks++; if (vg_wrd !== 1'b0) begin failures++; $display("FAIL async_reset_vg_wrd got=%b want=0", vg_wrd); end
    checks++; if (ovl !== 1'b0) begin failures++; $display("FAIL async_reset_ovl got=%b want=0", ovl); end
    #20 rst_n = 1'b1;
    for (int z = 0; z < 5; z++) begin
      pulse_wd(hints[z][2], hints[z][1], hints[z][0], -1, 3'd0, '0, r, f);
      checks++; if (r !== want[z] || f - r !== 7) begin failures++; $display("FAIL reset_table_zone%0d got=%0d/%0d want=%0d/7", z, r, f - r, want[z]); end
    end
  endtask

  initial begin
    test_reset();
    test_clock_normal();
    test_default_pulse();
    test_table_write();
    test_turbo();
    test_overlap();
    test_table_timing();
    test_reset_mid_pulse();
    checks++; if (min_phase < 7) begin failures++; $display("FAIL min_clk_phase got=%0d want>=7", min_phase); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
